// File: rtl/pixel_fifo_pkg.sv
// Shared defaults and width helpers for the pixel FIFO.
// Both the FIFO control logic and its storage take their sizes from here.
package pixel_fifo_pkg;

   localparam int DEF_DATA_W    = 24;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AF_MARGIN = 2;
   localparam int DEF_AF_THRESH = DEF_DEPTH - DEF_AF_MARGIN;
   localparam int DEF_AE_THRESH = 2;

   // Occupancy needs one extra bit so that a completely full FIFO (count == depth) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port storage for the pixel FIFO.
// It has one synchronous write port and an asynchronous read port, so it maps to distributed RAM.
module pixel_fifo_ram
   import pixel_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
)(
   input  logic                        clk,
   input  logic                        i_wr_en,
   input  logic [addr_w(DEPTH)-1:0]    i_wr_addr,
   input  logic [DATA_W-1:0]           i_wr_data,
   input  logic [addr_w(DEPTH)-1:0]    i_rd_addr,
   output logic [DATA_W-1:0]           o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Contents are intentionally never cleared; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with registered status flags, sticky error flags and optional FWFT output.
// Pointers, occupancy and the output register live here; the words themselves are held in pixel_fifo_ram.
module pixel_fifo
   import pixel_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
   parameter int AE_THRESH = DEF_AE_THRESH,
   parameter int FWFT      = 0
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          din,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          dout,
   output logic                       valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [cnt_w(DEPTH)-1:0]    count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_AF   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] C_AE   = CNT_W'(AE_THRESH);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_af;
   logic              r_ae;
   logic [DATA_W-1:0] r_dout;
   logic              r_valid;
   logic              r_ovf;
   logic              r_unf;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [CNT_W-1:0]  w_count_next;
   logic [DATA_W-1:0] w_rd_data;

   assign w_wr_acc = wr_en && !r_full;
   assign w_rd_acc = rd_en && !r_empty;

   always_comb begin
      w_count_next = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   pixel_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (din),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Flags are derived from the next count, so they line up with count in the cycle it changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_af     <= 1'b0;
         r_ae     <= 1'b1;
         r_dout   <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_dout   <= w_rd_data;
         end
         r_valid <= w_rd_acc;
         r_count <= w_count_next;
         r_full  <= (w_count_next == C_FULL);
         r_empty <= (w_count_next == '0);
         r_af    <= (w_count_next >= C_AF);
         r_ae    <= (w_count_next <= C_AE);
         if (wr_en && r_full) begin
            r_ovf <= 1'b1;
         end
         if (rd_en && r_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   // In FWFT mode the head word is visible straight from storage; it is zeroed while nothing is held.
   assign dout         = (FWFT != 0) ? (r_empty ? '0 : w_rd_data) : r_dout;
   assign valid        = (FWFT != 0) ? !r_empty : r_valid;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_af;
   assign almost_empty = r_ae;
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, the word width (one RGB pixel).
REQ-002 The block SHALL have parameter DEPTH, default 16, the storage depth; a power of two, at least 4.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2; almost_full asserts when count >= AF_THRESH.
REQ-004 The block SHALL have parameter AE_THRESH, default 2; almost_empty asserts when count <= AE_THRESH.
REQ-005 The block SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-008 The block SHALL have port din, input, DATA_W bits: write data.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-010 The block SHALL have port rd_en, input, 1 bit: read request (a pop in FWFT mode).
REQ-011 The block SHALL have port dout, output, DATA_W bits: read data.
REQ-012 The block SHALL have port valid, output, 1 bit: dout holds a read word.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit: status flags.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored words.
REQ-015 The block SHALL have ports overflow and underflow, each an output of 1 bit: sticky error flags.

Function
REQ-016 A write SHALL be accepted iff wr_en && !full; din is stored at the write pointer and the pointer advances modulo DEPTH.
REQ-017 A read SHALL be accepted iff rd_en && !empty; the read pointer advances modulo DEPTH.
REQ-018 A write while full SHALL be dropped, even if a read is accepted in the same cycle, and SHALL set overflow.
REQ-019 A read while empty SHALL be rejected, even if a write is accepted in the same cycle, and SHALL set underflow.
REQ-020 On a cycle where both a write and a read are accepted, count SHALL stay unchanged and data order SHALL be preserved.
REQ-021 count SHALL update on the clock edge after each accepted operation: +1 for a write only, -1 for a read only.
REQ-022 full, empty, almost_full and almost_empty SHALL be registered and consistent with count in the same cycle: full = (count==DEPTH), empty = (count==0).
REQ-023 With FWFT=0, dout SHALL present the read word one cycle after an accepted read, with valid high for exactly that cycle; dout holds its value otherwise.
REQ-024 With FWFT=1, dout SHALL show the head word combinationally whenever !empty, valid SHALL equal !empty, and rd_en SHALL pop the head.
REQ-025 With FWFT=1, a word written into an empty FIFO SHALL appear on dout, with valid high, in the cycle after the write.
REQ-026 Pointer wrap SHALL be seamless: DEPTH*3 consecutive write/read pairs SHALL return data in order.
REQ-027 overflow and underflow SHALL stay set until rst.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL zero both pointers and count, set empty=1, almost_empty=1, full=0, almost_full=0, valid=0, dout=0, overflow=0 and underflow=0.
REQ-029 rst SHALL take priority over wr_en and rd_en in the same cycle; that write or read SHALL be lost.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Asserting rst mid-operation SHALL discard all stored words.

Structure
REQ-032 The package pixel_fifo_pkg SHALL hold the default DATA_W, DEPTH and threshold constants, plus a function for the count width.
REQ-033 Storage SHALL be a sub-module pixel_fifo_ram: simple dual-port, one write port, read port asynchronous, mappable to distributed RAM.
REQ-034 Pointers, count, flags and the output register SHALL live in pixel_fifo.

Verification
REQ-035 FWFT=0: write 24'h123456, 24'h89abcd, 24'h342165, then hold rd_en 3 cycles -> dout returns those words in that order, one cycle after each read, valid high 3 cycles; empty=1 after.
REQ-036 Write 16 words 0..15 with DEPTH=16 -> full=1 and count=16; almost_full from count 14; a 17th write of 24'hFFFFFF -> dropped, overflow=1; read-back returns 0..15.
REQ-037 Read while empty -> no valid, underflow=1, count stays 0.
REQ-038 Prefill 8 words, then 48 cycles of simultaneous wr_en and rd_en with an incrementing pattern -> count stays 8 throughout and the output sequence is contiguous across pointer wrap.
REQ-039 Write 5 words, pulse rst for 1 cycle together with wr_en -> count=0, empty=1, flags cleared; a following write/read of 24'hABCDEF returns 24'hABCDEF.
REQ-040 FWFT=1: write 24'h55AA55 into an empty FIFO -> dout=24'h55AA55 with valid=1 on the next cycle; rd_en for 1 cycle -> empty=1 and valid=0.
